instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of instruction decode/control. Owns the PC, issues word
//  fetches to instruction memory over a req/valid handshake, and presents {instr, pc, pc+4}
//  to decode with a valid/stall handshake. A one-entry skid buffer absorbs a response
//  arriving while decode stalls. Branch/JAL/JALR redirects come back from execute.
// PARAMETERS
//  RESET_PC   32'h0000_0000  first fetch address after reset
//  NOP_INSTR  32'h0000_0013  value driven on if_instr whenever if_valid=0 (addi x0,x0,0)
// PORTS
//  clk           in   1   clock, all state updates on rising edge
//  rst_n         in   1   asynchronous active-low reset
//  imem_req      out  1   fetch request; held high with stable imem_addr until imem_valid
//  imem_addr     out  32  fetch address (word aligned)
//  imem_valid    in   1   response valid; may coincide with the req cycle (zero-wait)
//  imem_rdata    in   32  fetched instruction word, sampled when imem_valid=1
//  stall         in   1   decode cannot accept the presented instruction this cycle
//  redirect_en   in   1   taken branch / JAL / JALR; flushes fetch
//  redirect_pc   in   32  redirect target
//  if_valid      out  1   if_instr/if_pc/if_pc_plus4 are valid
//  if_instr      out  32  instruction to decode
//  if_pc         out  32  address of if_instr
//  if_pc_plus4   out  32  if_pc + 4 (link value for JAL/JALR)
//  fetch_fault   out  1   sticky: misaligned redirect target received
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, skid_valid=0, if_valid=0, if_instr=NOP_INSTR,
//   if_pc=0, if_pc_plus4=0, imem_req=0, imem_addr=RESET_PC, fetch_fault=0.
//  imem_req=1 only in REQ; imem_addr=pc always. One outstanding request max.
//  Consume: decode takes the output at an edge where if_valid=1 and stall=0.
//   slot_free = !if_valid || !stall.
//  States:
//   IDLE : -> REQ next cycle (first req exactly 1 cycle after rst_n rises).
//   REQ  : on imem_valid: pc<=pc+4; if slot_free load output regs (if_valid<=1,
//          if_instr<=rdata, if_pc<=pc, if_pc_plus4<=pc+4), stay REQ;
//          else load skid {rdata,pc}, -> HOLD. No imem_valid: if output consumed,
//          if_valid<=0; stay REQ.
//   HOLD : imem_req=0. When stall=0: output<=skid, skid_valid<=0, -> REQ.
//   DRAIN: imem_req=0; waits for stale response; on imem_valid discard it, -> REQ.
//   FAULT: imem_req=0, if_valid=0; exits only via reset.
//  Redirect (highest priority, any state except FAULT), effective next edge:
//   if_valid<=0, skid_valid<=0, if_instr<=NOP_INSTR, pc<=redirect_pc.
//   redirect_pc[1:0]!=0 -> fetch_fault<=1, -> FAULT.
//   In REQ with imem_valid=0 (response outstanding) -> DRAIN; else -> REQ.
//   Response arriving in the redirect cycle is discarded.
//  Throughput: zero-wait memory, stall=0 -> one instruction per cycle, if_valid constant 1.
//  Latency: imem_valid at edge N -> if_valid=1 after edge N.
//  Arithmetic: pc+4 is modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000, no fault).
//  stall while if_valid=0 is ignored. rst_n low mid-transaction: abandon outstanding
//   request, all regs to reset values immediately.
// TESTING
//  T1 reset, zero-wait mem, stall=0 -> req at 0x0,0x4,0x8 on consecutive cycles;
//     if_pc 0x0,0x4,0x8 with if_valid held 1; if_pc_plus4 = if_pc+4.
//  T2 3-cycle mem latency -> req/addr held stable 3 cycles; if_valid pulses 1 cycle per word.
//  T3 stall=1 for 4 cycles while response for 0x8 arrives -> output keeps 0x4 instr,
//     skid holds 0x8, req low; stall drops -> 0x8 presented next cycle, fetch 0xC resumes.
//  T4 redirect_en with redirect_pc=0x100 while request outstanding -> DRAIN, stale word
//     never reaches if_instr (if_instr=0x13), next req addr 0x100.
//  T5 redirect_pc=0x102 -> fetch_fault=1, imem_req=0, if_valid=0 until rst_n.
//  T6 RESET_PC=32'hFFFF_FFFC -> second fetch addr 0x0000_0000; rst_n pulsed mid-wait ->
//     next req at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches words from imem and presents {instr, pc, pc+4} to decode.
// Latency: imem_valid sampled at edge N -> if_valid=1 after edge N; zero-wait memory gives 1 instr/cycle.
// Backpressure: stall holds the output regs; a response landing under stall parks in a 1-entry skid.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   imem_req/imem_addr           fetch request, held with a stable word address until imem_valid
//   imem_valid/imem_rdata        fetch response (may arrive in the same cycle as the request)
//   stall                        decode cannot take the presented instruction this cycle
//   redirect_en/redirect_pc      taken branch / JAL / JALR target from execute; flushes fetch
//   if_valid/if_instr/if_pc/if_pc_plus4  instruction presented to decode (if_instr=NOP when invalid)
//   fetch_fault                  sticky: a misaligned redirect target was received
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {IDLE, REQ, HOLD, DRAIN, FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        out_vld_q, out_vld_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_pc4_q, out_pc4_d;
  logic        fault_q, fault_d;
  logic        slot_free;
  logic        consumed;

  // The output register can take a new word if it is empty or being taken this cycle.
  assign slot_free = !out_vld_q || !stall;
  assign consumed  = out_vld_q && !stall;

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign if_valid    = out_vld_q;
  assign if_instr    = out_instr_q;
  assign if_pc       = out_pc_q;
  assign if_pc_plus4 = out_pc4_q;
  assign fetch_fault = fault_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_vld_d   = skid_vld_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    out_vld_d    = out_vld_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_pc4_d    = out_pc4_q;
    fault_d      = fault_q;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_valid) begin
          pc_d = pc_q + 32'd4;
          if (slot_free) begin
            out_vld_d   = 1'b1;
            out_instr_d = imem_rdata;
            out_pc_d    = pc_q;
            out_pc4_d   = pc_q + 32'd4;
          end else begin
            skid_vld_d   = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = HOLD;
          end
        end else if (consumed) begin
          out_vld_d = 1'b0;
        end
      end
      HOLD: begin
        // Output is necessarily valid here, so stall=0 means decode takes it this edge.
        if (!stall) begin
          out_vld_d   = 1'b1;
          out_instr_d = skid_instr_q;
          out_pc_d    = skid_pc_q;
          out_pc4_d   = skid_pc_q + 32'd4;
          skid_vld_d  = 1'b0;
          state_d     = REQ;
        end
      end
      DRAIN: begin
        // Swallow the response to the request issued before the redirect.
        if (imem_valid) state_d = REQ;
      end
      FAULT: out_vld_d = 1'b0;
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything above; any response arriving this cycle is dropped.
    if (redirect_en && (state_q != FAULT)) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
      pc_d       = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        fault_d = 1'b1;
        state_d = FAULT;
      end else if (((state_q == REQ) || (state_q == DRAIN)) && !imem_valid) begin
        // A response is still owed by memory; a redirect during DRAIN keeps draining.
        state_d = DRAIN;
      end else begin
        state_d = REQ;
      end
    end

    // Decode always sees a NOP while nothing valid is presented.
    if (!out_vld_d) out_instr_d = NOP_INSTR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      skid_vld_q   <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      out_vld_q    <= 1'b0;
      out_instr_q  <= NOP_INSTR;
      out_pc_q     <= 32'h0;
      out_pc4_q    <= 32'h0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_vld_q   <= skid_vld_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      out_vld_q    <= out_vld_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      out_pc4_q    <= out_pc4_d;
      fault_q      <= fault_d;
    end
  end

endmodule
